alu_exec_stage: RTL
===================

# alu_exec_stage

Registered execute stage downstream of the ALU-control decoder. It accepts a decoded ALU select code plus two operands over a valid/ready handshake. It produces a registered result with zero and error flags. Logical and arithmetic ops complete in one cycle; shifts run iteratively, one bit per cycle, under a small state machine.

## Interface
- XLEN, 32: operand/result width; power of two, 8..64
- SHAMT_W, $clog2(XLEN): shift-amount width taken from src_b
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operands and select presented
- in_ready  out  1  stage can accept this cycle
- alu_ctl  in  `ALU_SEL_W  select code (`ALU_ADD`, `ALU_SUB`, `ALU_BNE`, `ALU_AND`, `ALU_OR`, `ALU_XOR`, `ALU_SLL`, `ALU_SRL`, `ALU_SRA`)
- src_a  in  XLEN  operand A
- src_b  in  XLEN  operand B / shift amount (low SHAMT_W bits)
- out_valid  out  1  result registered and held
- out_ready  in  1  consumer takes result
- result  out  XLEN  registered result
- zero  out  1  result == 0
- err  out  1  select code was illegal

## Operation
- States: IDLE, SHIFT.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- An accept occurs when in_valid && in_ready.
- Accept of ADD/SUB/AND/OR/XOR: result = a op b, modulo 2^XLEN. out_valid is set next cycle; state stays IDLE.
- Accept of BNE: result = (a != b) ? 1 : 0; single-cycle.
- Accept of shift with amount 0: result = src_a; single-cycle.
- Accept of shift with amount N > 0:
  - Load shift register with src_a and counter with N; go to SHIFT.
  - Each SHIFT cycle: shift by 1 (SLL zero-fill, SRL zero-fill, SRA sign-fill) and decrement the counter.
  - On the cycle the counter reaches 0: load result, set out_valid, return to IDLE.
- Illegal or zero select code: result = 0, err = 1, single-cycle.
- zero is computed from the registered result and is valid whenever out_valid is set.
- While out_valid && !out_ready, result, zero and err hold stable.
- out_valid drops the cycle after the consumer takes the result, unless a new accept reloads it in the same cycle (back-to-back throughput of 1/cycle for single-cycle ops).
- Inputs are ignored while in SHIFT. A new accept is blocked until the held result is consumed.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, zero 1, err 0, in_ready 1.
- Single-cycle op accepted at edge T: out_valid = 1 from T+1.
- Shift by N accepted at T: N cycles in SHIFT, out_valid = 1 from T+N+1.
- Simultaneous out_ready and in_valid with out_valid = 1 in IDLE: old result consumed and new accepted in the same cycle; new result appears next cycle.
- reset asserted mid-SHIFT: the shift is abandoned and all outputs return to reset values on the next edge.
- Shift amount is masked to SHAMT_W bits, so the maximum latency is XLEN cycles.

## Configuration
- `ALU_EXEC_SHIFT_EN` defined:
  - SLL/SRL/SRA are supported with the iterative SHIFT state.
- Not defined:
  - SHIFT state, shift register and counter are not built.
  - Shift codes are treated as illegal (result 0, err 1, single-cycle).
  - in_ready depends only on out_valid/out_ready.

## Structure
- Shared package: select codes (including the new `ALU_SLL`/`ALU_SRL`/`ALU_SRA`), `ALU_SEL_W`, and the state enum typedef.
- New codes are added to the common definitions header alongside the existing ones.
- One sub-module, alu_shift_iter, holds the shift register, counter and done pulse. It is instantiated only under `ALU_EXEC_SHIFT_EN`.

## Test plan
- ADD a=0xFFFFFFFF, b=1, out_ready=1 → result 0x00000000, zero 1, out_valid one cycle after accept.
- SRA a=0x80000000, b=4 → SHIFT for 4 cycles, result 0xF8000000, in_ready 0 throughout.
- Back-to-back XOR/SUB/BNE with out_ready tied 1 → one result per cycle; SUB 5−5 gives zero 1; BNE 5,5 gives result 0.
- Result held with out_ready=0 for 3 cycles after AND 0xF0F0,0x0FF0 → result 0x00F0 stable, in_ready 0; releasing out_ready lets the next op in.
- Select code 6'b000000 → result 0, err 1; repeat SLL with the macro undefined → err 1.
- reset pulsed on the 2nd cycle of SLL by 10 → out_valid 0, result 0, state IDLE; next ADD completes normally.

Source files
------------

// File: rtl/alu_exec_stage_pkg.sv
// alu_exec_stage_pkg
//   Shared definitions for the ALU execute stage. It holds the ALU select
//   codes and their width, the stage state enum, the shift-direction enum,
//   and helpers that classify select codes.
//   Optional feature macro: ALU_EXEC_SHIFT_EN. It enables the iterative shifts
//   in the stage that imports this package.
package alu_exec_stage_pkg;

  localparam int unsigned ALU_SEL_W = 6;

  localparam logic [ALU_SEL_W-1:0] ALU_ADD = 6'h01;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB = 6'h02;
  localparam logic [ALU_SEL_W-1:0] ALU_BNE = 6'h03;
  localparam logic [ALU_SEL_W-1:0] ALU_AND = 6'h04;
  localparam logic [ALU_SEL_W-1:0] ALU_OR  = 6'h05;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR = 6'h06;
  localparam logic [ALU_SEL_W-1:0] ALU_SLL = 6'h07;
  localparam logic [ALU_SEL_W-1:0] ALU_SRL = 6'h08;
  localparam logic [ALU_SEL_W-1:0] ALU_SRA = 6'h09;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_op_e;

  function automatic logic is_shift(input logic [ALU_SEL_W-1:0] sel);
    return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
  endfunction

  function automatic shift_op_e shift_op(input logic [ALU_SEL_W-1:0] sel);
    shift_op_e op;
    case (sel)
      ALU_SRL: op = SH_SRL;
      ALU_SRA: op = SH_SRA;
      default: op = SH_SLL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// alu_shift_iter
//   Iterative one-bit-per-cycle shifter used by alu_exec_stage. The stage
//   instantiates it only when ALU_EXEC_SHIFT_EN is defined.
//   Ports:
//     clk, reset  clock and synchronous active-high reset
//     start_i     load data_i/amt_i/op_i and begin shifting (amt_i must be > 0)
//     op_i        shift kind (SLL / SRL zero-fill, SRA sign-fill)
//     data_i      value to shift
//     amt_i       number of single-bit steps
//     done_o      high during the final step
//     result_o    value after the current step; it is final when done_o is high
module alu_shift_iter
  import alu_exec_stage_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  shift_op_e          op_i,
  input  logic [XLEN-1:0]    data_i,
  input  logic [SHAMT_W-1:0] amt_i,
  output logic               done_o,
  output logic [XLEN-1:0]    result_o
);

  logic               busy_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [XLEN-1:0]    sreg_q;
  shift_op_e          op_q;
  logic [XLEN-1:0]    step_d;

  always_comb begin
    step_d = sreg_q;
    case (op_q)
      SH_SLL:  step_d = {sreg_q[XLEN-2:0], 1'b0};
      SH_SRL:  step_d = {1'b0, sreg_q[XLEN-1:1]};
      SH_SRA:  step_d = {sreg_q[XLEN-1], sreg_q[XLEN-1:1]};
      default: step_d = sreg_q;
    endcase
  end

  // The step that takes the counter from 1 to 0 is the final one. The
  // shifted value is offered combinationally, so the stage can register it
  // on that same edge.
  assign done_o   = busy_q && (cnt_q == SHAMT_W'(1));
  assign result_o = step_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      sreg_q <= '0;
      op_q   <= SH_SLL;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= amt_i;
      sreg_q <= data_i;
      op_q   <= op_i;
    end else if (busy_q) begin
      sreg_q <= step_d;
      cnt_q  <= cnt_q - SHAMT_W'(1);
      if (cnt_q == SHAMT_W'(1)) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage
//   Registered ALU execute stage with a valid/ready handshake on both sides.
//   Logical, arithmetic and BNE ops complete in one cycle. When the
//   ALU_EXEC_SHIFT_EN macro is defined, the stage also supports SLL, SRL and
//   SRA. These run one bit per cycle in the SHIFT state. Without the macro,
//   the stage treats shift codes as illegal.
//   Ports:
//     clk, reset  clock and synchronous active-high reset
//     in_valid    operands and select presented
//     in_ready    stage can accept this cycle
//     alu_ctl     select code (see alu_exec_stage_pkg)
//     src_a       operand A
//     src_b       operand B; its low SHAMT_W bits give the shift amount
//     out_valid   result registered and held
//     out_ready   consumer takes the result
//     result      registered result
//     zero        result == 0
//     err         select code was illegal
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ALU_SEL_W-1:0] alu_ctl,
  input  logic [XLEN-1:0]      src_a,
  input  logic [XLEN-1:0]      src_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      result,
  output logic                 zero,
  output logic                 err
);

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            err_q, err_d;
  logic            accept;
  logic [XLEN-1:0] alu_res;
  logic            alu_err;

  assign accept = in_valid && in_ready;

`ifdef ALU_EXEC_SHIFT_EN
  state_e             state_q, state_d;
  logic [SHAMT_W-1:0] shamt;
  logic               shift_start;
  logic               shift_done;
  logic [XLEN-1:0]    shift_res;

  assign shamt       = src_b[SHAMT_W-1:0];
  assign shift_start = accept && is_shift(alu_ctl) && (shamt != '0);
  assign in_ready    = (state_q == IDLE) && (!out_valid_q || out_ready);

  alu_shift_iter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .start_i  (shift_start),
    .op_i     (shift_op(alu_ctl)),
    .data_i   (src_a),
    .amt_i    (shamt),
    .done_o   (shift_done),
    .result_o (shift_res)
  );
`else
  logic unused_shamt;

  assign unused_shamt = ^src_b[SHAMT_W-1:0];
  assign in_ready     = !out_valid_q || out_ready;
`endif

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (alu_ctl)
      ALU_ADD: alu_res = src_a + src_b;
      ALU_SUB: alu_res = src_a - src_b;
      ALU_BNE: alu_res = XLEN'(src_a != src_b);
      ALU_AND: alu_res = src_a & src_b;
      ALU_OR:  alu_res = src_a | src_b;
      ALU_XOR: alu_res = src_a ^ src_b;
`ifdef ALU_EXEC_SHIFT_EN
      // This value is used only for a zero shift amount. Non-zero amounts
      // go through the iterative shifter.
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = src_a;
`endif
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    err_d       = err_q;
`ifdef ALU_EXEC_SHIFT_EN
    state_d     = state_q;
`endif
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
`ifdef ALU_EXEC_SHIFT_EN
    if (shift_start) begin
      state_d = SHIFT;
    end else if (accept) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      err_d       = alu_err;
    end else if ((state_q == SHIFT) && shift_done) begin
      state_d     = IDLE;
      out_valid_d = 1'b1;
      result_d    = shift_res;
      err_d       = 1'b0;
    end
`else
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      err_d       = alu_err;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
`ifdef ALU_EXEC_SHIFT_EN
      state_q     <= IDLE;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      err_q       <= err_d;
`ifdef ALU_EXEC_SHIFT_EN
      state_q     <= state_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign err       = err_q;

endmodule
